// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/LSU memory port arbiter.
// Arbiter FSM states, owner encoding and counter width.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_LSU
  } owner_t;

  localparam int CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side and BRAM-side signals of the shared memory port.
// slave = arbiter view, master = core/memory environment view.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_valid;
  logic [DW-1:0] ls_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  mem_rdata,
    output if_gnt, if_valid, if_rdata,
    output ls_gnt, ls_valid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata,
    output mem_rdata,
    input  if_gnt, if_valid, if_rdata,
    input  ls_gnt, ls_valid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Two-input round-robin picker; bit0 = fetch, bit1 = LSU.
// On a tie the requester that did not own the port last wins.
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_t     last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = (last_i == OWN_FETCH) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port BRAM between fetch and load/store.
// One transaction in flight; all outputs registered.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AWIDTH  = 16,
  parameter int WDWIDTH = 32,
  parameter int RD_LAT  = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t         state_q, state_d;
  owner_t             owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               st_q, st_d;
  logic               if_gnt_q, if_gnt_d;
  logic               ls_gnt_q, ls_gnt_d;
  logic               if_val_q, if_val_d;
  logic               ls_val_q, ls_val_d;
  logic               en_q, en_d;
  logic               we_q, we_d;
  logic [AWIDTH-1:0]  addr_q, addr_d;
  logic [WDWIDTH-1:0] wdata_q, wdata_d;
  logic [WDWIDTH-1:0] if_rd_q, if_rd_d;
  logic [WDWIDTH-1:0] ls_rd_q, ls_rd_d;
  logic [1:0]         pick;

  rr_arbiter2 u_rr (
    .req_i  ({bus.ls_req, bus.if_req}),
    .last_i (owner_q),
    .gnt_o  (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_FETCH;
      cnt_q    <= '0;
      st_q     <= 1'b0;
      if_gnt_q <= 1'b0;
      ls_gnt_q <= 1'b0;
      if_val_q <= 1'b0;
      ls_val_q <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_rd_q  <= '0;
      ls_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      if_gnt_q <= if_gnt_d;
      ls_gnt_q <= ls_gnt_d;
      if_val_q <= if_val_d;
      ls_val_q <= ls_val_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      if_rd_q  <= if_rd_d;
      ls_rd_q  <= ls_rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    if_gnt_d = 1'b0;
    ls_gnt_d = 1'b0;
    if_val_d = 1'b0;
    ls_val_d = 1'b0;
    en_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if_rd_d  = if_rd_q;
    ls_rd_d  = ls_rd_q;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        // RESP arbitrates directly so back-to-back requests skip IDLE
        if (|pick) begin
          state_d  = ISSUE;
          owner_d  = pick[1] ? OWN_LSU : OWN_FETCH;
          if_gnt_d = pick[0];
          ls_gnt_d = pick[1];
          en_d     = 1'b1;
          we_d     = pick[1] & bus.ls_we;
          st_d     = pick[1] & bus.ls_we;
          addr_d   = pick[1] ? bus.ls_addr : bus.if_addr;
          if (pick[1]) begin
            wdata_d = bus.ls_wdata;
          end
        end
      end
      ISSUE: begin
        if (st_q) begin
          state_d  = RESP;
          ls_val_d = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT)) begin
          state_d = RESP;
          if (owner_q == OWN_LSU) begin
            ls_rd_d  = bus.mem_rdata;
            ls_val_d = 1'b1;
          end else begin
            if_rd_d  = bus.mem_rdata;
            if_val_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_valid  = if_val_q;
  assign bus.if_rdata  = if_rd_q;
  assign bus.ls_gnt    = ls_gnt_q;
  assign bus.ls_valid  = ls_val_q;
  assign bus.ls_rdata  = ls_rd_q;
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: RD_LAT=1 and RD_LAT=3 arbiters, each
// driving a small BRAM model with matching read latency.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if a_if ();
  mem_port_arbiter_if b_if ();

  mem_port_arbiter #(.RD_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (a_if)
  );

  mem_port_arbiter #(.RD_LAT(3)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if)
  );

  logic        bd_we = 1'b0;
  logic        bd_sel = 1'b0;
  logic [7:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  // non-enabled reads return junk so early capture is visible
  always @(posedge clk) begin
    if (bd_we && !bd_sel)
      mem_a[bd_addr] <= bd_data;
    else if (a_if.mem_en && a_if.mem_we)
      mem_a[a_if.mem_addr[7:0]] <= a_if.mem_wdata;
    if (bd_we && bd_sel)
      mem_b[bd_addr] <= bd_data;
    else if (b_if.mem_en && b_if.mem_we)
      mem_b[b_if.mem_addr[7:0]] <= b_if.mem_wdata;
    pipe_a <= a_if.mem_en ?
      mem_a[a_if.mem_addr[7:0]] : 32'hBAD0BAD0;
    pipe_b[0] <= b_if.mem_en ?
      mem_b[b_if.mem_addr[7:0]] : 32'hBAD1BAD1;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign a_if.mem_rdata = pipe_a;
  assign b_if.mem_rdata = pipe_b[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  initial begin
    a_if.if_req = 0; a_if.if_addr = '0;
    a_if.ls_req = 0; a_if.ls_we = 0;
    a_if.ls_addr = '0; a_if.ls_wdata = '0;
    b_if.if_req = 0; b_if.if_addr = '0;
    b_if.ls_req = 0; b_if.ls_we = 0;
    b_if.ls_addr = '0; b_if.ls_wdata = '0;

    // two reset cycles, used to preload the memories
    bd_we = 1; bd_sel = 0;
    bd_addr = 8'h10; bd_data = 32'hDEADBEEF;
    tick();
    bd_sel = 1; bd_addr = 8'h20; bd_data = 32'hCAFEF00D;
    tick();
    bd_we = 0;
    chk("rst_a_ctl", 64'({a_if.if_gnt, a_if.if_valid,
        a_if.ls_gnt, a_if.ls_valid,
        a_if.mem_en, a_if.mem_we}), 64'(0));
    chk("rst_a_ifrd", 64'(a_if.if_rdata), 64'(0));
    chk("rst_a_lsrd", 64'(a_if.ls_rdata), 64'(0));
    chk("rst_a_bus", 64'({a_if.mem_addr,
        a_if.mem_wdata}), 64'(0));
    chk("rst_b_ctl", 64'({b_if.if_gnt, b_if.if_valid,
        b_if.ls_gnt, b_if.ls_valid,
        b_if.mem_en, b_if.mem_we}), 64'(0));
    rst_a = 0; rst_b = 0;
    tick();
    chk("idle_a", 64'({a_if.if_gnt, a_if.ls_gnt,
        a_if.mem_en}), 64'(0));

    // single fetch, RD_LAT=1
    a_if.if_req = 1; a_if.if_addr = 16'h0010;
    tick();
    chk("f_gnt", 64'({a_if.if_gnt, a_if.ls_gnt}),
        64'(2'b10));
    chk("f_mem", 64'({a_if.mem_en, a_if.mem_we,
        a_if.mem_addr}), 64'({2'b10, 16'h0010}));
    a_if.if_req = 0; a_if.if_addr = 16'hFFFF;
    tick();
    chk("f_issue", 64'({a_if.if_gnt, a_if.mem_en,
        a_if.mem_we, a_if.if_valid}), 64'(0));
    tick();
    chk("f_valid", 64'({a_if.if_valid, a_if.ls_valid}),
        64'(2'b10));
    chk("f_rdata", 64'(a_if.if_rdata),
        64'(32'hDEADBEEF));
    chk("f_ls_quiet", 64'({a_if.ls_gnt, a_if.ls_valid,
        a_if.ls_rdata}), 64'(0));
    tick();
    chk("f_hold", 64'({a_if.if_valid, a_if.if_rdata}),
        64'({1'b0, 32'hDEADBEEF}));

    // store then load back
    a_if.ls_req = 1; a_if.ls_we = 1;
    a_if.ls_addr = 16'h0040; a_if.ls_wdata = 32'h12345678;
    tick();
    chk("s_gnt", 64'({a_if.if_gnt, a_if.ls_gnt}),
        64'(2'b01));
    chk("s_mem", 64'({a_if.mem_en, a_if.mem_we,
        a_if.mem_addr, a_if.mem_wdata}),
        64'({2'b11, 16'h0040, 32'h12345678}));
    a_if.ls_req = 0; a_if.ls_we = 0; a_if.ls_wdata = '0;
    tick();
    chk("s_valid", 64'({a_if.ls_valid, a_if.mem_en,
        a_if.mem_we}), 64'(3'b100));
    chk("s_rdata", 64'(a_if.ls_rdata), 64'(0));
    tick();
    chk("s_idle", 64'(a_if.ls_valid), 64'(0));
    a_if.ls_req = 1;
    tick();
    chk("l_gnt", 64'({a_if.if_gnt, a_if.ls_gnt,
        a_if.mem_we}), 64'(3'b010));
    a_if.ls_req = 0;
    tick();
    tick();
    chk("l_valid", 64'({a_if.if_valid, a_if.ls_valid}),
        64'(2'b01));
    chk("l_rdata", 64'(a_if.ls_rdata),
        64'(32'h12345678));
    chk("l_if_keep", 64'(a_if.if_rdata),
        64'(32'hDEADBEEF));

    // continuous tie after reset: LSU first, then alternate
    rst_a = 1;
    tick();
    tick();
    rst_a = 0;
    a_if.if_req = 1; a_if.if_addr = 16'h0010;
    a_if.ls_req = 1; a_if.ls_addr = 16'h0040;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("alt_gnt%0d", k),
          64'({a_if.if_gnt, a_if.ls_gnt}),
          64'((k % 2 == 0) ? 2'b01 : 2'b10));
      if (k == 5) begin
        a_if.if_req = 0; a_if.ls_req = 0;
      end
      tick();
      chk($sformatf("alt_wait%0d", k),
          64'({a_if.if_gnt, a_if.ls_gnt,
          a_if.if_valid, a_if.ls_valid}), 64'(0));
      tick();
      chk($sformatf("alt_val%0d", k),
          64'({a_if.if_valid, a_if.ls_valid}),
          64'((k % 2 == 0) ? 2'b01 : 2'b10));
      chk($sformatf("alt_rd%0d", k),
          64'((k % 2 == 0) ? a_if.ls_rdata : a_if.if_rdata),
          64'((k % 2 == 0) ? 32'h12345678 : 32'hDEADBEEF));
    end
    tick();
    chk("alt_idle", 64'({a_if.if_gnt, a_if.ls_gnt,
        a_if.mem_en}), 64'(0));

    // RD_LAT=3 load: valid exactly 5 cycles after req
    b_if.ls_req = 1; b_if.ls_addr = 16'h0020;
    tick();
    chk("b_gnt", 64'({b_if.if_gnt, b_if.ls_gnt}),
        64'(2'b01));
    b_if.ls_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("b_wait%0d", i),
          64'(b_if.ls_valid), 64'(0));
    end
    tick();
    chk("b_valid", 64'(b_if.ls_valid), 64'(1));
    chk("b_rdata", 64'(b_if.ls_rdata),
        64'(32'hCAFEF00D));
    tick();

    // reset while a fetch waits; pending LSU goes first
    b_if.if_req = 1; b_if.if_addr = 16'h0020;
    tick();
    chk("bf_gnt", 64'({b_if.if_gnt, b_if.ls_gnt}),
        64'(2'b10));
    b_if.if_req = 0; b_if.ls_req = 1;
    tick();
    tick();
    chk("bf_no_ls", 64'(b_if.ls_gnt), 64'(0));
    rst_b = 1;
    tick();
    chk("brst_ctl", 64'({b_if.if_gnt, b_if.if_valid,
        b_if.ls_gnt, b_if.ls_valid,
        b_if.mem_en, b_if.mem_we}), 64'(0));
    chk("brst_ifrd", 64'(b_if.if_rdata), 64'(0));
    rst_b = 0;
    tick();
    chk("brst_lsu1st", 64'({b_if.if_gnt, b_if.ls_gnt}),
        64'(2'b01));
    b_if.ls_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("brst_wait%0d", i),
          64'({b_if.if_valid, b_if.ls_valid}), 64'(0));
    end
    tick();
    chk("brst_lsval", 64'({b_if.if_valid, b_if.ls_valid}),
        64'(2'b01));
    chk("brst_lsrd", 64'(b_if.ls_rdata),
        64'(32'hCAFEF00D));
    chk("brst_ifrd2", 64'(b_if.if_rdata), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
